// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Latency: n/a (constants, types and a pure combinational helper).
// Backpressure: n/a.
//
// Contents: RV32I opcode constants used by the hazard logic, the sequencer
// state enum, and a helper that classifies control-transfer opcodes.
package pipe_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_BR_WAIT = 1'b1
    } state_t;

    // True for any instruction whose next PC is only known once EX resolves it.
    function automatic logic is_ctrl_xfer(input logic [6:0] opcode);
        return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source fields in ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by pipeline_ctrl in the same cycle.
//
// Ports:
//   i_ex_is_load  EX holds a load
//   i_ex_rd       EX destination register
//   i_id_rs1      id_instr[19:15]
//   i_id_rs2      id_instr[24:20] (compared for every opcode; conservative)
//   o_load_use    a one-bubble stall is needed
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_rd,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    output logic       o_load_use
);

    logic w_rd_nonzero;
    logic w_rd_match;

    // x0 is hard-wired zero, so a load into x0 never creates a dependency.
    assign w_rd_nonzero = (i_ex_rd != 5'd0);
    assign w_rd_match   = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);
    assign o_load_use   = i_ex_is_load && w_rd_nonzero && w_rd_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Prioritised stall/flush sequencer for PC, IF/ID and ID/EX, plus stall counter.
// Latency: enables/flushes are combinational from state and inputs; state and
// stall_cnt update on the rising clk edge. mem_busy freezes the whole pipeline.
//
// Ports:
//   clk, rst                 core clock; asynchronous active-high reset
//   id_valid, id_instr       instruction currently in ID
//   ex_is_load, ex_rd        load destination in EX (load-use detection)
//   ex_br_resolved/_taken    one-cycle resolution of a control transfer in EX
//   mem_busy                 data memory not ready
//   pc_enable, ifid_enable, idex_enable, ifid_flush, idex_flush  stage controls
//   stall_cnt                saturating count of cycles with pc_enable=0
//
// Build option: define PIPE_BR_PREDICT_NT_EN for predict-not-taken operation
// (BR_WAIT unused; only taken resolutions squash the two wrong-path slots).
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_resolved,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             idex_enable,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_load_use;
    logic             w_ctrl_xfer;

    hazard_detect u_hazard_detect (
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .i_id_rs1     (id_instr[19:15]),
        .i_id_rs2     (id_instr[24:20]),
        .o_load_use   (w_load_use)
    );

    assign w_ctrl_xfer = id_valid && is_ctrl_xfer(id_instr[6:0]);

    always_comb begin
        pc_enable    = 1'b1;
        ifid_enable  = 1'b1;
        idex_enable  = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        w_next_state = r_state;

        if (rst) begin
            // Reset forces bubbles into both latches without waiting for an edge.
            pc_enable    = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            w_next_state = ST_RUN;
        end else if (mem_busy) begin
            // Full freeze; a resolution pulse seen here is dropped, so EX must
            // keep it asserted until memory frees up.
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_enable = 1'b0;
        end else begin
`ifdef PIPE_BR_PREDICT_NT_EN
            w_next_state = ST_RUN;
            if (ex_br_resolved && ex_br_taken) begin
                // PC loads the target; IF and ID hold wrong-path instructions.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (w_load_use) begin
                pc_enable   = 1'b0;
                ifid_enable = 1'b0;
                idex_flush  = 1'b1;
            end
`else
            case (r_state)
                ST_RUN: begin
                    // A resolution pulse here has no branch to match; ignored.
                    if (w_load_use) begin
                        pc_enable   = 1'b0;
                        ifid_enable = 1'b0;
                        idex_flush  = 1'b1;
                    end else if (w_ctrl_xfer) begin
                        pc_enable    = 1'b0;
                        ifid_flush   = 1'b1;
                        w_next_state = ST_BR_WAIT;
                    end
                end
                ST_BR_WAIT: begin
                    // IF/ID keeps loading bubbles; ID/EX passes them down so the
                    // branch can advance into EX and resolve.
                    ifid_flush = 1'b1;
                    if (ex_br_resolved) begin
                        w_next_state = ST_RUN;
                    end else begin
                        pc_enable = 1'b0;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
`endif
        end
    end

`ifdef PIPE_BR_PREDICT_NT_EN
    logic w_unused;
    assign w_unused = ^{r_state, w_ctrl_xfer, id_instr[31:25], id_instr[14:7]};
`else
    logic w_unused;
    assign w_unused = ^{ex_br_taken, id_instr[31:25], id_instr[14:7]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Saturating stall counter: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!pc_enable && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver pushes the expected controls
// per cycle, a monitor pops and compares at the falling edge.
// Control vector order: {pc_enable, ifid_enable, idex_enable, ifid_flush, idex_flush}.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

`ifdef PIPE_BR_PREDICT_NT_EN
    localparam bit NT = 1'b1;
`else
    localparam bit NT = 1'b0;
`endif

    localparam logic [4:0] C_RST  = 5'b000_11;
    localparam logic [4:0] C_DEF  = 5'b111_00;
    localparam logic [4:0] C_LU   = 5'b001_01;
    localparam logic [4:0] C_BR   = 5'b011_10;
    localparam logic [4:0] C_RES  = 5'b111_10;
    localparam logic [4:0] C_FRZ  = 5'b000_00;
    localparam logic [4:0] C_SQ   = 5'b111_11;

    localparam logic [31:0] I_NOP = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] I_ADD = 32'h0012_8333; // add x6,x5,x1
    localparam logic [31:0] I_BEQ = 32'h0020_8063; // beq x1,x2,0

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [31:0]      id_instr;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             ex_br_resolved;
    logic             ex_br_taken;
    logic             mem_busy;
    logic             pc_enable;
    logic             ifid_enable;
    logic             idex_enable;
    logic             ifid_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct {
        string            name;
        logic [4:0]       ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .ex_is_load     (ex_is_load),
        .ex_rd          (ex_rd),
        .ex_br_resolved (ex_br_resolved),
        .ex_br_taken    (ex_br_taken),
        .mem_busy       (mem_busy),
        .pc_enable      (pc_enable),
        .ifid_enable    (ifid_enable),
        .idex_enable    (idex_enable),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus; expected stall_cnt comes from a saturating model
    // fed by the expected pc_enable of earlier cycles.
    task automatic step(input string nm, input logic r, input logic v,
                        input logic [31:0] ins, input logic ld, input logic [4:0] rd,
                        input logic res, input logic tk, input logic mb,
                        input logic [4:0] ectl);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        id_valid       = v;
        id_instr       = ins;
        ex_is_load     = ld;
        ex_rd          = rd;
        ex_br_resolved = res;
        ex_br_taken    = tk;
        mem_busy       = mb;
        if (r) exp_cnt = '0;
        e.name = nm;
        e.ctl  = ectl;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        if (!r && !ectl[4] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    endtask

    // Monitor: outputs are meaningful every cycle, so one entry per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({pc_enable, ifid_enable, idex_enable, ifid_flush, idex_flush} !== e.ctl) begin
                    errors++;
                    $display("FAIL %s ctl: got %b expected %b", e.name,
                             {pc_enable, ifid_enable, idex_enable, ifid_flush, idex_flush}, e.ctl);
                end
                checks++;
                if (stall_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1; id_valid = 1'b0; id_instr = I_NOP; ex_is_load = 1'b0; ex_rd = 5'd0;
        ex_br_resolved = 1'b0; ex_br_taken = 1'b0; mem_busy = 1'b0;

        // Reset and release
        step("reset0", 1, 0, I_NOP, 0, 0, 0, 0, 0, C_RST);
        step("reset1", 1, 0, I_NOP, 0, 0, 0, 0, 0, C_RST);
        step("idle0",  0, 1, I_NOP, 0, 0, 0, 0, 0, C_DEF);
        step("idle1",  0, 1, I_NOP, 0, 0, 0, 0, 0, C_DEF);

        // Load-use on rs1, then on rs2, and the x0 exemption
        step("lu_rs1",   0, 1, I_ADD, 1, 5, 0, 0, 0, C_LU);
        step("lu_after", 0, 1, I_ADD, 0, 0, 0, 0, 0, C_DEF);
        step("ld_x0",    0, 1, I_NOP, 1, 0, 0, 0, 0, C_DEF);
        step("lu_rs2",   0, 1, I_ADD, 1, 1, 0, 0, 0, C_LU);
        step("ld_nodep", 0, 1, I_ADD, 1, 7, 0, 0, 0, C_DEF);

        // Branch taken, resolved two cycles after entering ID
        step("br_ent",  0, 1, I_BEQ, 0, 0, 0, 0, 0, NT ? C_DEF : C_BR);
        step("br_wait", 0, NT, I_NOP, 0, 0, 0, 0, 0, NT ? C_DEF : C_BR);
        step("br_res",  0, 1, I_NOP, 0, 0, 1, 1, 0, NT ? C_SQ  : C_RES);
        step("br_run",  0, 1, I_NOP, 0, 0, 0, 0, 0, C_DEF);

        // Branch not taken
        step("bnt_ent",  0, 1, I_BEQ, 0, 0, 0, 0, 0, NT ? C_DEF : C_BR);
        step("bnt_wait", 0, NT, I_NOP, 0, 0, 0, 0, 0, NT ? C_DEF : C_BR);
        step("bnt_res",  0, 1, I_NOP, 0, 0, 1, 0, 0, NT ? C_DEF : C_RES);
        step("bnt_run",  0, 1, I_NOP, 0, 0, 0, 0, 0, C_DEF);

        // Stray resolution in RUN; resolution versus load-use in one cycle
        step("stray_res", 0, 1, I_NOP, 0, 0, 1, 1, 0, NT ? C_SQ : C_DEF);
        step("res_vs_lu", 0, 1, I_ADD, 1, 5, 1, 1, 0, NT ? C_SQ : C_LU);
        step("rvl_after", 0, 1, I_NOP, 0, 0, 0, 0, 0, C_DEF);

        // mem_busy for three cycles while a resolution is held
        step("mb_ent",  0, 1, I_BEQ, 0, 0, 0, 0, 0, NT ? C_DEF : C_BR);
        step("mb_0",    0, 0, I_NOP, 0, 0, 1, 1, 1, C_FRZ);
        step("mb_1",    0, 0, I_NOP, 0, 0, 1, 1, 1, C_FRZ);
        step("mb_2",    0, 0, I_NOP, 0, 0, 1, 1, 1, C_FRZ);
        step("mb_res",  0, 0, I_NOP, 0, 0, 1, 1, 0, NT ? C_SQ : C_RES);
        step("mb_run",  0, 1, I_NOP, 0, 0, 0, 0, 0, C_DEF);

        // Reset while waiting on a branch discards it
        step("rb_ent",  0, 1, I_BEQ, 0, 0, 0, 0, 0, NT ? C_DEF : C_BR);
        step("rb_rst",  1, 0, I_NOP, 0, 0, 0, 0, 0, C_RST);
        step("rb_rel",  0, 1, I_NOP, 0, 0, 0, 0, 0, C_DEF);
        step("rb_res",  0, 1, I_NOP, 0, 0, 1, 0, 0, C_DEF);

        // Held load-use drives the 4-bit counter into saturation
        for (int i = 0; i < 20; i++) begin
            step("sat_lu", 0, 1, I_ADD, 1, 5, 0, 0, 0, C_LU);
        end
        step("sat_end", 0, 1, I_NOP, 0, 0, 0, 0, 0, C_DEF);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
